// File: rtl/vote_collector.sv
// Ballot collector feeding the weighted vote evaluator.
// Gathers one ballot per voter over valid/ready, builds the registered
// np/vip/vvip yes-masks, and latches the evaluator verdict when the round closes.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, no round active, ballots not accepted
// OPEN   | round active, ballots accepted and recorded
// SETTLE | one cycle with frozen vectors so the evaluator output settles
// DONE   | result latched and valid until the next start
module vote_collector #(
    parameter int ID_W       = 6,
    parameter bit AUTO_CLOSE = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            close,
    input  logic            ballot_valid,
    output logic            ballot_ready,
    input  logic [ID_W-1:0] ballot_id,
    input  logic            ballot_yes,
    output logic [31:0]     np,
    output logic [7:0]      vip,
    output logic            vvip,
    input  logic            res_in,
    output logic            result,
    output logic            result_valid,
    output logic            dup_err,
    output logic            id_err,
    output logic [5:0]      accepted
);

    typedef enum logic [1:0] {IDLE, OPEN, SETTLE, DONE} state_t;

    localparam logic [5:0] N_VOTERS = 6'd41;

    state_t      state_q, state_d;
    logic [31:0] np_q, np_d;
    logic [7:0]  vip_q, vip_d;
    logic        vvip_q, vvip_d;
    logic [40:0] voted_q, voted_d;
    logic [5:0]  accepted_q, accepted_d;
    logic        result_q, result_d;
    logic        result_valid_q, result_valid_d;
    logic        dup_err_q, dup_err_d;
    logic        id_err_q, id_err_d;

    logic [63:0] id_onehot;
    logic        id_illegal;
    logic        already_voted;

    // Decode the presented ID into a one-hot voter select and classify it.
    assign id_onehot     = 64'd1 << ballot_id[5:0];
    assign id_illegal    = (ballot_id > ID_W'(40));
    assign already_voted = |(voted_q & id_onehot[40:0]);

    // Next-state, ballot recording and verdict capture.
    always_comb begin
        state_d        = state_q;
        np_d           = np_q;
        vip_d          = vip_q;
        vvip_d         = vvip_q;
        voted_d        = voted_q;
        accepted_d     = accepted_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        dup_err_d      = 1'b0;
        id_err_d       = 1'b0;
        ballot_ready   = (state_q == OPEN);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d        = OPEN;
                    np_d           = '0;
                    vip_d          = '0;
                    vvip_d         = 1'b0;
                    voted_d        = '0;
                    accepted_d     = '0;
                    result_valid_d = 1'b0;
                end
            end
            OPEN: begin
                if (start) begin
                    // Restart: any ballot presented this cycle is dropped silently.
                    np_d       = '0;
                    vip_d      = '0;
                    vvip_d     = 1'b0;
                    voted_d    = '0;
                    accepted_d = '0;
                end else begin
                    if (ballot_valid) begin
                        if (id_illegal) begin
                            id_err_d = 1'b1;
                        end else if (already_voted) begin
                            dup_err_d = 1'b1;
                        end else begin
                            voted_d    = voted_q | id_onehot[40:0];
                            np_d       = (np_q & ~id_onehot[31:0]) |
                                         ({32{ballot_yes}} & id_onehot[31:0]);
                            vip_d      = (vip_q & ~id_onehot[39:32]) |
                                         ({8{ballot_yes}} & id_onehot[39:32]);
                            vvip_d     = id_onehot[40] ? ballot_yes : vvip_q;
                            accepted_d = accepted_q + 6'd1;
                        end
                    end
                    // accepted_d already includes a ballot consumed this cycle.
                    if (close || (AUTO_CLOSE && (accepted_d == N_VOTERS))) begin
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                result_d       = res_in;
                result_valid_d = 1'b1;
                state_d        = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            np_q           <= '0;
            vip_q          <= '0;
            vvip_q         <= 1'b0;
            voted_q        <= '0;
            accepted_q     <= '0;
            result_q       <= 1'b0;
            result_valid_q <= 1'b0;
            dup_err_q      <= 1'b0;
            id_err_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            np_q           <= np_d;
            vip_q          <= vip_d;
            vvip_q         <= vvip_d;
            voted_q        <= voted_d;
            accepted_q     <= accepted_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            dup_err_q      <= dup_err_d;
            id_err_q       <= id_err_d;
        end
    end

    assign np           = np_q;
    assign vip          = vip_q;
    assign vvip         = vvip_q;
    assign accepted     = accepted_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign dup_err      = dup_err_q;
    assign id_err       = id_err_q;

endmodule

// File: tb/tb_vote_collector.sv
// Bench for vote_collector: directed rounds with a scoreboard monitor for
// round results and error pulses, plus a reference evaluator driving res_in.
module tb_vote_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        close = 1'b0;
    logic        ballot_valid = 1'b0;
    logic        ballot_ready;
    logic [5:0]  ballot_id = '0;
    logic        ballot_yes = 1'b0;
    logic [31:0] np;
    logic [7:0]  vip;
    logic        vvip;
    logic        res_in;
    logic        result;
    logic        result_valid;
    logic        dup_err;
    logic        id_err;
    logic [5:0]  accepted;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        result;
        logic [31:0] np;
        logic [7:0]  vip;
        logic        vvip;
        logic [5:0]  accepted;
    } round_t;

    round_t res_q[$];
    int     err_q[$];   // 1 = dup_err pulse expected, 2 = id_err pulse expected

    vote_collector #(.ID_W(6), .AUTO_CLOSE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .close(close),
        .ballot_valid(ballot_valid), .ballot_ready(ballot_ready),
        .ballot_id(ballot_id), .ballot_yes(ballot_yes),
        .np(np), .vip(vip), .vvip(vvip), .res_in(res_in),
        .result(result), .result_valid(result_valid),
        .dup_err(dup_err), .id_err(id_err), .accepted(accepted)
    );

    always #5 clk = ~clk;

    // Reference evaluator: regular weight 1, vip weight 4, vvip weight 16.
    int weight;
    always_comb begin
        weight = $countones(np) + 4 * $countones(vip) + 16 * int'(vvip);
        res_in = (weight > 32);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every result and error pulse against the scoreboard.
    logic rv_prev = 1'b0;
    initial begin
        round_t e;
        int     k;
        forever begin
            @(negedge clk);
            if (result_valid && !rv_prev) begin
                if (res_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = res_q.pop_front();
                    check("result", {63'd0, result}, {63'd0, e.result});
                    check("res_np", {32'd0, np}, {32'd0, e.np});
                    check("res_vip", {56'd0, vip}, {56'd0, e.vip});
                    check("res_vvip", {63'd0, vvip}, {63'd0, e.vvip});
                    check("res_accepted", {58'd0, accepted}, {58'd0, e.accepted});
                end
            end
            if (dup_err) begin
                k = (err_q.size() == 0) ? 0 : err_q.pop_front();
                check("dup_err_pulse", 64'(k), 64'd1);
            end
            if (id_err) begin
                k = (err_q.size() == 0) ? 0 : err_q.pop_front();
                check("id_err_pulse", 64'(k), 64'd2);
            end
            rv_prev = result_valid;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic vote(input int id, input bit yes, input bit with_close);
        ballot_valid = 1'b1;
        ballot_id    = 6'(id);
        ballot_yes   = yes;
        close        = with_close;
        @(posedge clk); #1;
        ballot_valid = 1'b0;
        close        = 1'b0;
    endtask

    task automatic pulse_close();
        close = 1'b1;
        @(posedge clk); #1;
        close = 1'b0;
    endtask

    // Called just after the edge that moved the FSM into SETTLE.
    task automatic settle_check();
        @(negedge clk);
        check("settle_ready", {63'd0, ballot_ready}, 0);
        check("settle_rv", {63'd0, result_valid}, 0);
        @(negedge clk);
        check("done_rv", {63'd0, result_valid}, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        round_t r;

        // Reset values
        #12;
        check("rst_np", {32'd0, np}, 0);
        check("rst_vip", {56'd0, vip}, 0);
        check("rst_vvip", {63'd0, vvip}, 0);
        check("rst_rv", {63'd0, result_valid}, 0);
        check("rst_acc", {58'd0, accepted}, 0);
        check("rst_ready", {63'd0, ballot_ready}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_close();
        repeat (2) @(posedge clk);
        #1;
        check("idle_close_ignored", {63'd0, result_valid}, 0);

        // Round 1: regular voters only, weight 32 -> no
        pulse_start();
        @(negedge clk);
        check("open_ready", {63'd0, ballot_ready}, 1);
        r = '{result: 1'b0, np: 32'hFFFF_FFFF, vip: 8'h00, vvip: 1'b0, accepted: 6'd32};
        res_q.push_back(r);
        for (int i = 0; i < 32; i++) vote(i, 1'b1, 1'b0);
        pulse_close();
        settle_check();

        // Round 2: plus vip 0, weight 36 -> yes
        pulse_start();
        @(negedge clk);
        check("restart_rv_clear", {63'd0, result_valid}, 0);
        r = '{result: 1'b1, np: 32'hFFFF_FFFF, vip: 8'h01, vvip: 1'b0, accepted: 6'd33};
        res_q.push_back(r);
        for (int i = 0; i < 33; i++) vote(i, 1'b1, 1'b0);
        pulse_close();
        settle_check();

        // Round 3: vvip + 4 vips, weight 32 -> no
        pulse_start();
        r = '{result: 1'b0, np: 32'h0, vip: 8'h0F, vvip: 1'b1, accepted: 6'd5};
        res_q.push_back(r);
        vote(40, 1'b1, 1'b0);
        for (int i = 32; i < 36; i++) vote(i, 1'b1, 1'b0);
        pulse_close();
        settle_check();

        // Round 4: same plus id 7, weight 33 -> yes
        pulse_start();
        r = '{result: 1'b1, np: 32'h80, vip: 8'h0F, vvip: 1'b1, accepted: 6'd6};
        res_q.push_back(r);
        vote(40, 1'b1, 1'b0);
        for (int i = 32; i < 36; i++) vote(i, 1'b1, 1'b0);
        vote(7, 1'b1, 1'b0);
        pulse_close();
        settle_check();

        // Round 5: duplicate and illegal ballots, back-to-back offenders
        pulse_start();
        vote(5, 1'b1, 1'b0);
        err_q.push_back(1);
        vote(5, 1'b0, 1'b0);
        err_q.push_back(2);
        vote(45, 1'b1, 1'b0);
        @(negedge clk);
        check("dup_np5_kept", {63'd0, np[5]}, 1);
        check("err_acc", {58'd0, accepted}, 1);
        err_q.push_back(2);
        err_q.push_back(1);
        vote(63, 1'b1, 1'b0);
        vote(5, 1'b1, 1'b0);
        vote(6, 1'b0, 1'b0);
        @(negedge clk);
        check("no_vote_np6", {63'd0, np[6]}, 0);
        r = '{result: 1'b0, np: 32'h20, vip: 8'h00, vvip: 1'b0, accepted: 6'd2};
        res_q.push_back(r);
        pulse_close();
        settle_check();

        // Round 6: all 41 vote, last ballot together with close
        pulse_start();
        r = '{result: 1'b1, np: 32'hFFFF_FFFF, vip: 8'hFF, vvip: 1'b1, accepted: 6'd41};
        res_q.push_back(r);
        for (int i = 0; i < 40; i++) vote(i, 1'b1, 1'b0);
        vote(40, 1'b1, 1'b1);
        settle_check();
        repeat (3) @(posedge clk);
        #1;

        // Round 7: auto-close without close; mixed votes (np 0x0000FFFF, vip 0x0F, vvip 0)
        pulse_start();
        r = '{result: 1'b0, np: 32'h0000_FFFF, vip: 8'h0F, vvip: 1'b0, accepted: 6'd41};
        res_q.push_back(r);
        for (int i = 0; i < 41; i++) vote(i, (i < 16) || (i >= 32 && i < 36), 1'b0);
        settle_check();

        // Restart in OPEN drops the concurrent ballot without error
        pulse_start();
        vote(3, 1'b1, 1'b0);
        start = 1'b1;
        vote(4, 1'b1, 1'b0);
        start = 1'b0;
        @(negedge clk);
        check("restart_np", {32'd0, np}, 0);
        check("restart_acc", {58'd0, accepted}, 0);
        check("restart_ready", {63'd0, ballot_ready}, 1);
        vote(3, 1'b1, 1'b0);
        @(negedge clk);
        check("revote_acc", {58'd0, accepted}, 1);

        // Asynchronous reset mid-round
        for (int i = 0; i < 3; i++) vote(i, 1'b1, 1'b0);
        @(negedge clk);
        check("pre_rst_np", {32'd0, np}, 32'h0000_000F);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_np", {32'd0, np}, 0);
        check("arst_acc", {58'd0, accepted}, 0);
        check("arst_ready", {63'd0, ballot_ready}, 0);
        check("arst_rv", {63'd0, result_valid}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        vote(9, 1'b1, 1'b0);
        @(negedge clk);
        check("post_rst_acc", {58'd0, accepted}, 0);
        check("post_rst_np", {32'd0, np}, 0);

        // Empty round after reset: weight 0 -> no
        pulse_start();
        r = '{result: 1'b0, np: 32'h0, vip: 8'h00, vvip: 1'b0, accepted: 6'd0};
        res_q.push_back(r);
        pulse_close();
        settle_check();

        repeat (4) @(posedge clk);
        #1;
        check("results_drained", 64'(res_q.size()), 0);
        check("errors_drained", 64'(err_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
